exec_trace_monitor: RTL and testbench

EXEC_TRACE_MONITOR -- requirements
Module: exec_trace_monitor

---
 rtl/exec_trace_monitor.sv | 152 +++++++++++++++
 tb/tb_exec_trace_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_trace_monitor.sv
// Execution trace monitor: holds a core in reset, then records one trace entry per run cycle
// into a circular buffer until the core halts (PC self-loop) or the cycle budget runs out.
module exec_trace_monitor #(
  parameter int unsigned PC_W        = 5,
  parameter int unsigned INST_W      = 16,
  parameter int unsigned DMA_W       = 4,
  parameter int unsigned DMD_W       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 50,
  parameter int unsigned HALT_REPEAT = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic                                  core_reset,
  input  logic [PC_W-1:0]                       curr_inst_addr,
  input  logic [PC_W-1:0]                       next_inst_addr,
  input  logic [INST_W-1:0]                     curr_inst,
  input  logic [DMA_W-1:0]                      addr_on_dm,
  input  logic [DMD_W-1:0]                      data_on_dm,
  input  logic                                  rd_en,
  output logic [PC_W+INST_W+DMA_W+DMD_W-1:0]    rd_data,
  output logic                                  rd_valid,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  overflow,
  output logic [15:0]                           cycle_cnt,
  output logic                                  done,
  output logic                                  timeout
);

  localparam int unsigned EW  = PC_W + INST_W + DMA_W + DMD_W;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned HRW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {StHold, StRun, StDone, StTimeout} state_e;

  state_e           state_q, state_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [HRW-1:0]   halt_cnt_q, halt_cnt_d;
  logic [15:0]      cycle_cnt_q, cycle_cnt_d;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             rd_valid_q;
  logic [EW-1:0]    rd_data_q;

  logic             push, pop, full;
  logic [EW-1:0]    entry;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      halt_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      halt_cnt_q  <= halt_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next-state logic; halt is tested before the budget so it wins a tie.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    halt_cnt_d  = halt_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HCW'(RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      StRun: begin
        cycle_cnt_d = cycle_cnt_q + 16'd1;
        halt_cnt_d  = (next_inst_addr == curr_inst_addr) ? halt_cnt_q + HRW'(1) : '0;
        if (halt_cnt_d == HRW'(HALT_REPEAT)) begin
          state_d = StDone;
        end else if (cycle_cnt_d == 16'(MAX_CYCLES)) begin
          state_d = StTimeout;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    core_reset = (state_q != StRun);
    done       = (state_q == StDone);
    timeout    = (state_q == StTimeout);
    cycle_cnt  = cycle_cnt_q;
    count      = count_q;
    overflow   = overflow_q;
    rd_valid   = rd_valid_q;
    rd_data    = rd_data_q;
  end

  assign entry = {curr_inst_addr, curr_inst, addr_on_dm, data_on_dm};
  assign push  = (state_q == StRun);
  assign pop   = rd_en && (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= entry;
    end
  end

  // Reading the old slot on the same edge as the write lets a full pop+push return the oldest.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop || (push && full)) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        if (full) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Bench for exec_trace_monitor: vector table, directed corner sequences and a randomized
// run checked against a queue-based reference model.
module tb_exec_trace_monitor;

  localparam int PC_W = 5, INST_W = 16, DMA_W = 4, DMD_W = 8;
  localparam int DEPTH = 16, RST_CYCLES = 2, MAX_CYCLES = 50, HALT_REPEAT = 3;
  localparam int EW = PC_W + INST_W + DMA_W + DMD_W;
  localparam int PH_HOLD = 0, PH_RUN = 1, PH_DONE = 2, PH_TIMEOUT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_reset;
  logic [PC_W-1:0]   curr_inst_addr, next_inst_addr;
  logic [INST_W-1:0] curr_inst;
  logic [DMA_W-1:0]  addr_on_dm;
  logic [DMD_W-1:0]  data_on_dm;
  logic              rd_en;
  logic [EW-1:0]     rd_data;
  logic              rd_valid;
  logic [4:0]        count;
  logic              overflow;
  logic [15:0]       cycle_cnt;
  logic              done, timeout;

  always #5 clk = ~clk;

  exec_trace_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .core_reset     (core_reset),
    .curr_inst_addr (curr_inst_addr),
    .next_inst_addr (next_inst_addr),
    .curr_inst      (curr_inst),
    .addr_on_dm     (addr_on_dm),
    .data_on_dm     (data_on_dm),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .count          (count),
    .overflow       (overflow),
    .cycle_cnt      (cycle_cnt),
    .done           (done),
    .timeout        (timeout)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: phase, counters and a queue holding the trace, oldest first.
  int            m_phase = PH_HOLD;
  int            m_hold_seen = 0;
  int            m_cycles = 0;
  int            m_repeats = 0;
  bit            m_over = 0;
  bit            m_rd_valid = 0;
  logic [EW-1:0] m_rd_data = '0;
  logic [EW-1:0] m_q[$];

  task automatic model_step();
    bit do_pop;
    if (reset) begin
      m_phase = PH_HOLD; m_hold_seen = 0; m_cycles = 0; m_repeats = 0;
      m_over = 0; m_rd_valid = 0; m_rd_data = '0; m_q.delete();
    end else begin
      do_pop = rd_en && (m_q.size() > 0);
      m_rd_valid = do_pop;
      if (do_pop) m_rd_data = m_q.pop_front();
      if (m_phase == PH_RUN) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_over = 1;
        end
        m_q.push_back({curr_inst_addr, curr_inst, addr_on_dm, data_on_dm});
        m_cycles++;
        m_repeats = (next_inst_addr == curr_inst_addr) ? m_repeats + 1 : 0;
        if (m_repeats == HALT_REPEAT) m_phase = PH_DONE;
        else if (m_cycles == MAX_CYCLES) m_phase = PH_TIMEOUT;
      end else if (m_phase == PH_HOLD) begin
        m_hold_seen++;
        if (m_hold_seen == RST_CYCLES) m_phase = PH_RUN;
      end
    end
  endtask

  task automatic compare_model();
    check("model.core_reset", core_reset, m_phase != PH_RUN);
    check("model.count", count, m_q.size());
    check("model.overflow", overflow, m_over);
    check("model.cycle_cnt", cycle_cnt, m_cycles);
    check("model.done", done, m_phase == PH_DONE);
    check("model.timeout", timeout, m_phase == PH_TIMEOUT);
    check("model.rd_valid", rd_valid, m_rd_valid);
    check("model.rd_data", rd_data, m_rd_data);
  endtask

  // One clock: drive inputs, step DUT and model on the edge, compare 1 time unit later.
  task automatic tick(input bit rst, input bit rde, input logic [PC_W-1:0] ca,
                      input logic [PC_W-1:0] na);
    reset          = rst;
    rd_en          = rde;
    curr_inst_addr = ca;
    next_inst_addr = na;
    curr_inst      = INST_W'($urandom);
    addr_on_dm     = DMA_W'($urandom);
    data_on_dm     = DMD_W'($urandom);
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  typedef struct {
    bit         rst;
    bit         rde;
    logic [4:0] ca;
    logic [4:0] na;
    bit         e_crst;
    int         e_count;
    int         e_cyc;
    bit         e_done;
    bit         e_to;
    bit         e_rv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Reset, hold, then PC 0..3 and a three-cycle self loop at 3 ending in DONE.
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 2, 0, 2, 2, 0, 0, 0};
    tbl[5]  = '{0, 0, 2, 3, 0, 3, 3, 0, 0, 0};
    tbl[6]  = '{0, 0, 3, 4, 0, 4, 4, 0, 0, 0};
    tbl[7]  = '{0, 0, 3, 3, 0, 5, 5, 0, 0, 0};
    tbl[8]  = '{0, 0, 3, 3, 0, 6, 6, 0, 0, 0};
    tbl[9]  = '{0, 0, 3, 3, 1, 7, 7, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 7, 7, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 1, 6, 7, 1, 0, 1};

    reset = 1; rd_en = 0; curr_inst_addr = '0; next_inst_addr = '0;
    curr_inst = '0; addr_on_dm = '0; data_on_dm = '0;

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].rst, tbl[i].rde, tbl[i].ca, tbl[i].na);
      check($sformatf("vec%0d.core_reset", i), core_reset, tbl[i].e_crst);
      check($sformatf("vec%0d.count", i), count, tbl[i].e_count);
      check($sformatf("vec%0d.cycle_cnt", i), cycle_cnt, tbl[i].e_cyc);
      check($sformatf("vec%0d.done", i), done, tbl[i].e_done);
      check($sformatf("vec%0d.timeout", i), timeout, tbl[i].e_to);
      check($sformatf("vec%0d.rd_valid", i), rd_valid, tbl[i].e_rv);
    end
    check("halt.first_pop_pc", rd_data[EW-1 -: PC_W], 0);

    // Overflow after 17 pushes, pop during push, then run to timeout.
    do_reset();
    for (int k = 0; k < 17; k++) tick(0, 0, PC_W'(k), PC_W'(k + 1));
    check("wrap.overflow", overflow, 1);
    check("wrap.count", count, 16);
    tick(0, 1, 17, 18);
    check("wrap.rd_valid", rd_valid, 1);
    check("wrap.first_pop_pc", rd_data[EW-1 -: PC_W], 1);
    check("wrap.count_after_pop", count, 16);
    for (int k = 18; k < 50; k++) tick(0, 0, PC_W'(k), PC_W'(k + 1));
    check("to.timeout", timeout, 1);
    check("to.done", done, 0);
    check("to.cycle_cnt", cycle_cnt, 50);
    check("to.count", count, 16);
    check("to.overflow", overflow, 1);
    check("to.core_reset", core_reset, 1);

    // Exactly full, then pop with push: no overflow, oldest returned.
    do_reset();
    for (int k = 0; k < 16; k++) tick(0, 0, PC_W'(k), PC_W'(k + 1));
    check("full.count", count, 16);
    check("full.overflow", overflow, 0);
    tick(0, 1, 16, 17);
    check("full_pp.count", count, 16);
    check("full_pp.overflow", overflow, 0);
    check("full_pp.rd_valid", rd_valid, 1);
    check("full_pp.pc", rd_data[EW-1 -: PC_W], 0);

    // Reset pulsed mid-run restarts the hold sequence.
    do_reset();
    for (int k = 0; k < 10; k++) tick(0, 0, PC_W'(k), PC_W'(k + 1));
    tick(1, 0, 10, 11);
    check("rst.count", count, 0);
    check("rst.overflow", overflow, 0);
    check("rst.cycle_cnt", cycle_cnt, 0);
    check("rst.core_reset", core_reset, 1);
    tick(0, 0, 0, 1);
    check("rst.hold1", core_reset, 1);
    tick(0, 0, 0, 1);
    check("rst.run", core_reset, 0);

    // Randomized episodes; odd episodes favour self loops to reach DONE.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int c = 0; c < 90; c++) begin
        logic [PC_W-1:0] ca, na;
        bit same;
        ca   = PC_W'($urandom);
        same = (ep % 2 == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
        na   = same ? ca : PC_W'($urandom);
        tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, ca, na);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
